// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit for a word-only dmem port: sub-word loads with sign/zero
// extension, sub-word stores through read-modify-write, and access-fault checks.
module lsu_dmem_ctrl #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [15:0] wdata_q;

    logic            illegal_c;
    logic            misaligned_c;
    logic            out_of_range_c;
    logic            req_err_c;
    logic [4:0]      shamt_c;
    logic [15:0]     lane_data_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] merge_mask_c;
    logic [XLEN-1:0] merge_data_c;
    logic [XLEN-1:0] merged_c;

    // Handshake and dmem strobes are combinational so reset can suppress them in the same cycle
    assign req_ready = (state == IDLE) && !rst;
    assign mem_read  = ((state == LOAD) || (state == RMW_RD)) && !rst;
    assign mem_write = ((state == WR) || (state == RMW_WR)) && !rst;

    // Fault classification of the incoming request
    always_comb begin
        illegal_c      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111) ||
                         (req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
        misaligned_c   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        out_of_range_c = req_addr >= XLEN'(ADDR_LIMIT);
        req_err_c      = illegal_c || misaligned_c || out_of_range_c;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        shamt_c      = {lane_q, 3'b000};
        lane_data_c  = 16'(mem_rdata >> shamt_c);
        load_data_c  = mem_rdata;
        merge_mask_c = XLEN'(32'h0000_00FF) << shamt_c;
        merge_data_c = XLEN'({24'b0, wdata_q[7:0]}) << shamt_c;
        case (funct3_q)
            3'b000:  load_data_c = {{24{lane_data_c[7]}}, lane_data_c[7:0]};
            3'b001:  load_data_c = {{16{lane_data_c[15]}}, lane_data_c};
            3'b100:  load_data_c = {24'b0, lane_data_c[7:0]};
            3'b101:  load_data_c = {16'b0, lane_data_c};
            default: load_data_c = mem_rdata;
        endcase
        if (funct3_q[0]) begin
            merge_mask_c = XLEN'(32'h0000_FFFF) << shamt_c;
            merge_data_c = XLEN'({16'b0, wdata_q}) << shamt_c;
        end
        merged_c = (mem_rdata & ~merge_mask_c) | merge_data_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lane_q     <= 2'b00;
            funct3_q   <= 3'b000;
            wdata_q    <= 16'h0000;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lane_q     <= req_addr[1:0];
                        funct3_q   <= req_funct3;
                        wdata_q    <= req_wdata[15:0];
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        mem_wdata  <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= req_err_c;
                        if (req_err_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            state <= WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_data_c;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    mem_wdata <= merged_c;
                    state     <= RMW_WR;
                end
                RMW_WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
